// File: rtl/decode_stage_fwd_if.sv
// Decode stage bundle: fetch-side inputs, writeback, bypass lanes
// and the registered decode outputs toward execute.
interface decode_stage_fwd_if #(
  parameter int XLEN = 16,
  parameter int NFWD = 2
);
  logic                 in_valid;
  logic [15:0]          instr;
  logic                 stall;
  logic                 flush;
  logic                 wb_en;
  logic [2:0]           wb_addr;
  logic [XLEN-1:0]      wb_data;
  logic [NFWD-1:0]      fwd_valid;
  logic [NFWD-1:0]      fwd_pending;
  logic [3*NFWD-1:0]    fwd_idx;
  logic [XLEN*NFWD-1:0] fwd_data;
  logic                 stall_req;
  logic                 out_valid;
  logic [3:0]           opcode;
  logic                 imm_flag;
  logic [2:0]           rd;
  logic [4:0]           imm;
  logic [XLEN-1:0]      op1;
  logic [XLEN-1:0]      op2;
  logic [XLEN-1:0]      branch_target;

  modport master (
    output in_valid, instr, stall, flush,
    output wb_en, wb_addr, wb_data,
    output fwd_valid, fwd_pending, fwd_idx, fwd_data,
    input  stall_req, out_valid, opcode, imm_flag,
    input  rd, imm, op1, op2, branch_target
  );

  modport slave (
    input  in_valid, instr, stall, flush,
    input  wb_en, wb_addr, wb_data,
    input  fwd_valid, fwd_pending, fwd_idx, fwd_data,
    output stall_req, out_valid, opcode, imm_flag,
    output rd, imm, op1, op2, branch_target
  );
endinterface

// File: rtl/decode_stage_fwd.sv
// Decode stage with register file, prioritised bypass lanes,
// hazard stall request and a one-cycle output register.
module decode_stage_fwd #(
  parameter int XLEN = 16,
  parameter int NFWD = 2,
  parameter int NREG = 8
) (
  input logic          clk,
  input logic          reset,
  decode_stage_fwd_if.slave bus
);

  typedef struct packed {
    logic            valid;
    logic [3:0]      opcode;
    logic            imm_flag;
    logic [2:0]      rd;
    logic [4:0]      imm;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] bt;
  } out_t;

  logic [XLEN-1:0] regs [NREG];

  logic [1:0][2:0]      src;
  logic [1:0][XLEN-1:0] opnd;
  logic [1:0]           haz;
  logic [1:0]           hit;
  logic                 immf;
  logic                 hz;

  out_t d;
  out_t q;

  assign immf = bus.instr[11];

  // Register file: writeback lands every edge, independent of stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.wb_en) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Operand resolution: youngest matching lane, then writeback, then file.
  always_comb begin
    src[0] = bus.instr[7:5];
    src[1] = bus.instr[4:2];
    hit    = '0;
    haz    = '0;
    for (int j = 0; j < 2; j++) begin
      opnd[j] = regs[src[j]];
      if (bus.wb_en && bus.wb_addr == src[j]) begin
        opnd[j] = bus.wb_data;
      end
      for (int k = 0; k < NFWD; k++) begin
        if (!hit[j] && bus.fwd_valid[k] &&
            bus.fwd_idx[3*k +: 3] == src[j]) begin
          hit[j]  = 1'b1;
          haz[j]  = bus.fwd_pending[k];
          opnd[j] = bus.fwd_data[XLEN*k +: XLEN];
        end
      end
    end
  end

  // An immediate second operand never waits on a lane.
  assign hz = haz[0] | (haz[1] & ~immf);
  assign bus.stall_req = bus.in_valid & hz;

  // Decoded bundle as it would be loaded this edge.
  always_comb begin
    d          = '0;
    d.valid    = 1'b1;
    d.opcode   = bus.instr[15:12];
    d.imm_flag = immf;
    d.rd       = bus.instr[10:8];
    d.imm      = bus.instr[4:0];
    d.op1      = opnd[0];
    d.op2      = opnd[1];
    if (immf) begin
      d.op2      = '0;
      d.op2[4:0] = bus.instr[4:0];
    end
    d.bt[10:0] = bus.instr[10:0];
  end

  // Pipeline register: flush beats stall; stall holds; else bubble or load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (bus.flush) begin
      q <= '0;
    end else if (!bus.stall) begin
      if (!bus.in_valid || bus.stall_req) begin
        q <= '0;
      end else begin
        q <= d;
      end
    end
  end

  assign bus.out_valid     = q.valid;
  assign bus.opcode        = q.opcode;
  assign bus.imm_flag      = q.imm_flag;
  assign bus.rd            = q.rd;
  assign bus.imm           = q.imm;
  assign bus.op1           = q.op1;
  assign bus.op2           = q.op2;
  assign bus.branch_target = q.bt;

endmodule

// File: tb/tb_decode_stage_fwd.sv
// Bench for decode_stage_fwd: directed vectors, a cycle model
// compared every cycle, plus literal checks on key results.
module tb_decode_stage_fwd;

  localparam int XLEN = 16;
  localparam int NFWD = 2;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  decode_stage_fwd_if #(.XLEN(XLEN), .NFWD(NFWD)) bus ();

  decode_stage_fwd #(.XLEN(XLEN), .NFWD(NFWD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- model ----
  logic [15:0] mreg [8];
  logic        e_v, e_f;
  logic [3:0]  e_opc;
  logic [2:0]  e_rd;
  logic [4:0]  e_imm;
  logic [15:0] e_op1, e_op2, e_bt;

  function automatic int lane_of(logic [2:0] s);
    for (int k = 0; k < NFWD; k++)
      if (bus.fwd_valid[k] && bus.fwd_idx[3*k +: 3] == s) return k;
    return -1;
  endfunction

  function automatic logic m_haz(logic [2:0] s);
    int l = lane_of(s);
    return (l >= 0) && bus.fwd_pending[l];
  endfunction

  function automatic logic [15:0] m_val(logic [2:0] s);
    int l = lane_of(s);
    if (l >= 0) return bus.fwd_data[16*l +: 16];
    if (bus.wb_en && bus.wb_addr == s) return bus.wb_data;
    return mreg[s];
  endfunction

  function automatic logic m_sreq();
    logic [15:0] i = bus.instr;
    return bus.in_valid &
           (m_haz(i[7:5]) | (m_haz(i[4:2]) & ~i[11]));
  endfunction

  task automatic m_bubble();
    e_v = 0; e_f = 0; e_opc = 0; e_rd = 0;
    e_imm = 0; e_op1 = 0; e_op2 = 0; e_bt = 0;
  endtask

  always @(negedge clk) begin
    logic [15:0] i;
    if (reset) begin
      m_bubble();
      for (int r = 0; r < 8; r++) mreg[r] = 0;
    end
    chk("out_valid", bus.out_valid, e_v);
    chk("opcode", bus.opcode, e_opc);
    chk("imm_flag", bus.imm_flag, e_f);
    chk("rd", bus.rd, e_rd);
    chk("imm", bus.imm, e_imm);
    chk("op1", bus.op1, e_op1);
    chk("op2", bus.op2, e_op2);
    chk("branch_target", bus.branch_target, e_bt);
    chk("stall_req", bus.stall_req, m_sreq());
    if (!reset) begin
      i = bus.instr;
      if (bus.flush) m_bubble();
      else if (bus.stall) ;
      else if (!bus.in_valid || m_sreq()) m_bubble();
      else begin
        e_v = 1; e_opc = i[15:12]; e_f = i[11];
        e_rd = i[10:8]; e_imm = i[4:0];
        e_op1 = m_val(i[7:5]);
        e_op2 = i[11] ? {11'd0, i[4:0]} : m_val(i[4:2]);
        e_bt = {5'd0, i[10:0]};
      end
      if (bus.wb_en) mreg[bus.wb_addr] = bus.wb_data;
    end
  end

  // ---- stimulus ----
  function automatic logic [15:0] mk(logic [3:0] op, logic f,
      logic [2:0] d, logic [2:0] s1, logic [4:0] lo);
    return {op, f, d, s1, lo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1;
    bus.in_valid = 0; bus.instr = 0; bus.stall = 0; bus.flush = 0;
    bus.wb_en = 0; bus.wb_addr = 0; bus.wb_data = 0;
    bus.fwd_valid = 0; bus.fwd_pending = 0;
    bus.fwd_idx = 0; bus.fwd_data = 0;
    m_bubble();
    for (int r = 0; r < 8; r++) mreg[r] = 0;
    tick(); tick();
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset op1", bus.op1, 0);
    reset = 0;

    // 1: write r3, then read it on both sources
    bus.wb_en = 1; bus.wb_addr = 3; bus.wb_data = 16'h1234;
    tick();
    bus.wb_en = 0;
    bus.in_valid = 1;
    bus.instr = mk(4'h1, 0, 3'd1, 3'd3, 5'h0C);
    tick();
    chk("t1 op1", bus.op1, 16'h1234);
    chk("t1 op2", bus.op2, 16'h1234);
    chk("t1 valid", bus.out_valid, 1);
    chk("t1 opcode", bus.opcode, 4'h1);
    chk("t1 bt", bus.branch_target, 16'h016C);

    // 2: lane priority
    bus.fwd_valid = 2'b11;
    bus.fwd_idx = {3'd2, 3'd2};
    bus.fwd_data = {16'h5555, 16'hAAAA};
    bus.instr = mk(4'h2, 0, 3'd2, 3'd2, 5'h00);
    tick();
    chk("t2 lane0", bus.op1, 16'hAAAA);
    bus.fwd_valid = 2'b10;
    tick();
    chk("t2 lane1", bus.op1, 16'h5555);

    // 3: immediate skips the pending lane; register form stalls
    bus.fwd_valid = 2'b01; bus.fwd_pending = 2'b01;
    bus.fwd_idx = {3'd0, 3'd7};
    bus.instr = mk(4'h3, 1, 3'd4, 3'd0, 5'h1F);
    #1 chk("t3 sreq imm", bus.stall_req, 0);
    tick();
    chk("t3 op2", bus.op2, 16'h001F);
    chk("t3 valid", bus.out_valid, 1);
    bus.instr = mk(4'h3, 0, 3'd4, 3'd0, 5'h1F);
    #1 chk("t3 sreq reg", bus.stall_req, 1);
    tick();
    chk("t3 bubble", bus.out_valid, 0);
    chk("t3 bubble op2", bus.op2, 0);

    // 4: hold across a 3-cycle stall, wb r5 during it
    bus.fwd_valid = 0; bus.fwd_pending = 0;
    bus.instr = mk(4'h4, 0, 3'd5, 3'd3, 5'h00);
    tick();
    chk("t4 load", bus.out_valid, 1);
    bus.stall = 1;
    for (int c = 0; c < 3; c++) begin
      bus.instr = mk(4'h9 + c[3:0], 0, 3'd6, 3'd0, 5'h04);
      bus.wb_en = (c == 0);
      bus.wb_addr = 5; bus.wb_data = 16'h5A5A;
      tick();
      chk("t4 hold opc", bus.opcode, 4'h4);
      chk("t4 hold op1", bus.op1, 16'h1234);
    end
    bus.stall = 0; bus.wb_en = 0;
    bus.instr = mk(4'h5, 0, 3'd0, 3'd5, 5'h00);
    tick();
    chk("t4 r5", bus.op1, 16'h5A5A);

    // 5: flush with stall, wb r1
    bus.flush = 1; bus.stall = 1;
    bus.wb_en = 1; bus.wb_addr = 1; bus.wb_data = 16'h00FF;
    bus.instr = mk(4'h6, 0, 3'd1, 3'd3, 5'h0C);
    tick();
    chk("t5 flush valid", bus.out_valid, 0);
    chk("t5 flush opc", bus.opcode, 0);
    chk("t5 flush op1", bus.op1, 0);
    bus.flush = 0; bus.stall = 0; bus.wb_en = 0;
    bus.instr = mk(4'h7, 0, 3'd2, 3'd1, 5'h00);
    tick();
    chk("t5 r1", bus.op1, 16'h00FF);

    // 6: write-through, then async reset
    bus.wb_en = 1; bus.wb_addr = 4; bus.wb_data = 16'hBEEF;
    bus.instr = mk(4'h8, 0, 3'd0, 3'd4, 5'h00);
    tick();
    chk("t6 wt", bus.op1, 16'hBEEF);
    bus.wb_en = 0;
    tick();
    chk("t6 pre-reset", bus.out_valid, 1);
    #2 reset = 1;
    #1;
    chk("t6 async valid", bus.out_valid, 0);
    chk("t6 async op1", bus.op1, 0);
    tick();
    reset = 0;
    bus.in_valid = 0;
    tick();
    chk("t6 post bubble", bus.out_valid, 0);
    bus.in_valid = 1;
    tick();
    chk("t6 r4 cleared", bus.op1, 0);
    chk("t6 valid", bus.out_valid, 1);
    bus.in_valid = 0;
    tick();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
